// File: rtl/corr_frame_tx.sv
// Correlation frame transmitter: snapshots a count bus on a strobe and sends it out as 8N1 UART bytes.
// Optional trailing XOR checksum byte is enabled with `define CORR_FRAME_CHECKSUM_EN.
module corr_frame_tx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400,
  parameter int RESOLUTION    = 16,
  parameter int NUM_COUNTS    = 91
) (
  input  logic                               clki,
  input  logic                               reset,
  input  logic                               integration_clk_pulse,
  input  logic [NUM_COUNTS*RESOLUTION-1:0]   counts,
  output logic                               TX,
  output logic                               busy,
  output logic                               overrun
);

  localparam int DIV    = CLK_FREQUENCY / BAUD_RATE;
  localparam int BPC    = RESOLUTION / 8;
  localparam int NDATA  = NUM_COUNTS * BPC;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BYTE_W = (NDATA > 2) ? $clog2(NDATA) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BYTE_W-1:0] DATA_LAST = BYTE_W'(NDATA - 1);
  localparam logic [BYTE_W-1:0] SYNC_LAST = BYTE_W'(1);

`ifdef CORR_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, CSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic [NDATA-1:0][7:0]   snap_q, snap_d, snap_in;
  logic                    tx_q, tx_d;
  logic                    ovr_q, ovr_d;
  logic                    accept;
  logic [7:0]              cur_byte;
  logic [2:0]              bsel;

  assign busy    = (state_q != IDLE);
  assign TX      = tx_q;
  assign overrun = ovr_q;
  assign accept  = integration_clk_pulse && !busy;

  // Snapshot is stored in transmission order: count 0 first, MSB byte first.
  always_comb begin
    snap_in = '0;
    for (int k = 0; k < NUM_COUNTS; k++)
      for (int b = 0; b < BPC; b++)
        snap_in[k*BPC + b] = counts[k*RESOLUTION + (BPC-1-b)*8 +: 8];
  end

`ifdef CORR_FRAME_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int j = 0; j < NDATA; j++) csum = csum ^ snap_q[j];
  end
`endif

  // Next-state: baud counter -> bit counter -> byte counter -> state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    ovr_d   = ovr_q | (integration_clk_pulse & busy);
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SYNC;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
        snap_d  = snap_in;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        bit_d  = '0;
        byte_d = byte_q + 1'b1;
        case (state_q)
          SYNC: if (byte_q == SYNC_LAST) begin
            state_d = DATA;
            byte_d  = '0;
          end
          DATA: if (byte_q == DATA_LAST) begin
            byte_d = '0;
`ifdef CORR_FRAME_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
`endif
          end
`ifdef CORR_FRAME_CHECKSUM_EN
          CSUM: begin
            state_d = IDLE;
            byte_d  = '0;
          end
`endif
          default: state_d = IDLE;
        endcase
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  // TX is registered from the next-state position so each bit starts cleanly on an edge.
  always_comb begin
    cur_byte = 8'hFF;
    case (state_d)
      SYNC:    cur_byte = (byte_d == '0) ? 8'hA5 : 8'h5A;
      DATA:    cur_byte = snap_q[byte_d];
`ifdef CORR_FRAME_CHECKSUM_EN
      CSUM:    cur_byte = csum;
`endif
      default: cur_byte = 8'hFF;
    endcase
    bsel = bit_d[2:0] - 3'd1;
    if (state_d == IDLE)      tx_d = 1'b1;
    else if (bit_d == 4'd0)   tx_d = 1'b0;
    else if (bit_d == 4'd9)   tx_d = 1'b1;
    else                      tx_d = cur_byte[bsel];
  end

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: doc/corr_frame_tx.md
CORR_FRAME_TX -- requirements
Module: corr_frame_tx

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 230400, UART bit rate.
REQ-003 SHALL have parameter RESOLUTION, default 16, bits per correlation count (multiple of 8).
REQ-004 SHALL have parameter NUM_COUNTS, default 91, number of correlation counts per frame.
REQ-005 SHALL have port clki  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port integration_clk_pulse  input  1  one-cycle strobe marking end of an integration window.
REQ-008 SHALL have port counts  input  NUM_COUNTS*RESOLUTION  flat count bus; count k occupies bits [k*RESOLUTION +: RESOLUTION].
REQ-009 SHALL have port TX  output  1  UART 8N1 serial output, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in flight.
REQ-011 SHALL have port overrun  output  1  sticky flag: strobe arrived while busy.

Function
REQ-012 SHALL use bit period DIV = CLK_FREQUENCY/BAUD_RATE clocks (integer truncation); every bit held exactly DIV cycles.
REQ-013 SHALL, on integration_clk_pulse sampled high with busy low, latch all of counts into an internal snapshot in that cycle; later changes to counts SHALL not affect the frame.
REQ-014 SHALL drive TX low (start bit of first byte) and busy high on the cycle after the accepting strobe.
REQ-015 SHALL use states IDLE -> SYNC -> DATA -> (CSUM) -> IDLE; each byte = start bit 0, 8 data bits LSB first, stop bit 1, no gap between bytes.
REQ-016 SHALL send in SYNC bytes 0xA5 then 0x5A.
REQ-017 SHALL send in DATA count 0 through count NUM_COUNTS-1, each MSB byte first, RESOLUTION/8 bytes per count.
REQ-018 SHALL return to IDLE and deassert busy on the cycle after the final stop bit's last cycle; TX stays high in IDLE.
REQ-019 SHALL ignore integration_clk_pulse while busy is high (including the final stop-bit cycle) and set overrun to 1 in the following cycle; frame in flight unaffected.
REQ-020 SHALL keep overrun set until reset.
REQ-021 SHALL make frame length 2 + NUM_COUNTS*RESOLUTION/8 bytes (plus 1 with checksum).

Reset
REQ-022 SHALL, on reset asserted (any time, including mid-bit), immediately force TX=1, busy=0, overrun=0, state IDLE, snapshot, bit and baud counters to 0.
REQ-023 SHALL accept a strobe on the first rising edge with reset deasserted.

Configuration
REQ-024 SHALL, with macro CORR_FRAME_CHECKSUM_EN defined, append one CSUM byte equal to XOR of all DATA bytes (sync bytes excluded) after the last DATA byte.
REQ-025 SHALL, without CORR_FRAME_CHECKSUM_EN, go DATA -> IDLE directly; no checksum logic present.

Verification (bench: CLK_FREQUENCY=4, BAUD_RATE=1 so DIV=4; NUM_COUNTS=2, RESOLUTION=16)
REQ-026 SHALL test basic frame: counts={16'h1234,16'hABCD} (count0=ABCD), strobe -> bytes A5,5A,AB,CD,12,34 decoded; TX low 1 cycle after strobe; busy high 240 cycles.
REQ-027 SHALL test checksum: CORR_FRAME_CHECKSUM_EN, same stimulus -> seventh byte 0xAB^0xCD^0x12^0x34=0x40; busy high 280 cycles.
REQ-028 SHALL test snapshot: change counts to 0 one cycle after strobe -> frame still carries AB,CD,12,34.
REQ-029 SHALL test overrun: second strobe 100 cycles into frame -> frame unchanged, overrun=1 next cycle and stays 1; strobe after busy falls starts new frame.
REQ-030 SHALL test reset mid-frame: reset at cycle 50 of frame -> TX=1, busy=0, overrun=0 immediately; next strobe yields full frame starting with A5.
REQ-031 SHALL test boundary: strobe on last stop-bit cycle -> rejected, overrun=1; strobe on first cycle busy=0 -> accepted.
